reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Power-up and fault reset controller sitting directly below the top-level clock/PLL block. Holds several downstream reset domains in reset until the PLL has been stably locked, then releases them one at a time in fixed order, stage 0 first, with a programmable gap between releases. Re-asserts all domains at once on PLL lock loss or on a software reset request. All outputs are synchronous to i_clk and feed the per-domain resets of the datapath.

## Interface
- NUM_STAGES, 4: number of sequenced reset outputs; legal range 1..8.
- LOCK_FILTER, 256: consecutive synchronized-lock cycles required before the first release; must be ≥1.
- STAGE_DELAY, 1024: cycles between consecutive stage releases; must be ≥1.
- SYNC_CYCLE, 2: synchronizer depth for i_arst release and i_pll_locked; must be ≥2.
- i_clk  in  1  free-running reference clock.
- i_arst  in  1  reset, asynchronous, active-low.
- i_pll_locked  in  1  PLL lock, asynchronous to i_clk.
- i_sw_rst_req  in  1  synchronous single-cycle request to re-run the sequence.
- o_srst  out  NUM_STAGES  per-stage reset, active-high; bit k is released k-th.
- o_rst_done  out  1  high while every stage is released.
- o_state  out  2  FSM state: 0 HOLD, 1 FILTER, 2 RELEASE, 3 RUN.

## Operation
- Internal reset: i_arst goes through an async-assert, sync-release synchronizer of depth SYNC_CYCLE. While it is active: o_srst all ones, o_rst_done 0, o_state HOLD, all counters 0.
- i_pll_locked goes through a SYNC_CYCLE-flop synchronizer, giving lock_s.
- HOLD: all stages asserted. When lock_s=1, move to FILTER with filter count 0.
- FILTER: the filter count increments each cycle that lock_s=1.
  - lock_s=0: return to HOLD and clear the count.
  - Count = LOCK_FILTER-1 with lock_s=1: move to RELEASE. o_srst[0] drops on that same edge, and the stage count becomes 1.
- RELEASE: the delay counter counts 0..STAGE_DELAY-1. On wrap, deassert o_srst[stage] and increment stage.
  - When the last bit drops, move to RUN and set o_rst_done on the same edge.
  - If NUM_STAGES=1, FILTER goes directly to RUN.
- RUN: hold the state until a fault or request.
- Fault or request: lock_s=0, or i_sw_rst_req=1, in FILTER, RELEASE or RUN.
  - On the next edge, all o_srst bits go to 1, o_rst_done goes to 0, the state goes to HOLD, and all counters clear.
  - Lock loss takes the same path as a request. Both together: same single action.
- i_sw_rst_req in HOLD is ignored.
- Released bits never re-assert individually. Assertion is always all-at-once.
- Counter widths: $clog2 of LOCK_FILTER, STAGE_DELAY and NUM_STAGES (minimum 1 bit each). No overflow is possible because every counter saturates into a state change.

## Timing
- i_arst low: o_srst goes to all ones asynchronously, with no clock needed.
- i_arst release: internal reset deasserts SYNC_CYCLE edges later.
- Lock latency: i_pll_locked rising reaches lock_s after SYNC_CYCLE edges.
- Release times, measured in edges from the first cycle with lock_s=1 in HOLD:
  - HOLD→FILTER: 1 edge.
  - o_srst[0] falls: LOCK_FILTER edges after FILTER entry.
  - o_srst[k] falls: k·STAGE_DELAY edges after o_srst[0].
  - o_rst_done rises: with the last stage.
- Fault or request to all-asserted: 1 edge after the lock_s/request sample, i.e. SYNC_CYCLE+1 edges from a raw lock drop.
- Re-run after a request with lock still present: HOLD for 1 cycle, then FILTER, then the full sequence again.

## Structure
- Shared package reset_seq_pkg: state enum (HOLD/FILTER/RELEASE/RUN, 2-bit encoding as above) and a parameter-legality check function.
- Reuse the existing common_reset module for the i_arst synchronizer: IN_RST_ACTIVE "LOW", OUT_RST_ACTIVE "HIGH", CYCLE=SYNC_CYCLE.
- Lock synchronizer: a local flop chain. The FSM and counters live in a single always block.

## Test plan
Parameters for all benches: NUM_STAGES=3, LOCK_FILTER=8, STAGE_DELAY=4, SYNC_CYCLE=2.
- Power-up: hold i_arst low, lock=1 → o_srst=3'b111, done=0, state=0. Release i_arst → o_srst[0] falls 8 cycles after FILTER entry, [1] falls 4 cycles later, [2] 4 cycles after that with done=1, state=3.
- Lock glitch: lock_s low for 1 cycle at filter count 5 → back to HOLD. A full 8-cycle filter restarts and no stage releases early.
- Lock loss in RUN: drop i_pll_locked → o_srst=3'b111 and done=0 exactly 3 edges later. Restore lock → the full sequence repeats.
- Software request mid-RELEASE: pulse i_sw_rst_req after o_srst[0] releases → all ones next edge, then HOLD→FILTER→full sequence. A pulse in HOLD has no effect.
- Simultaneous: lock loss and request on the same cycle in RUN → a single all-assert; state=HOLD.
- Async reset mid-RELEASE: i_arst low → o_srst=3'b111 with no clock edge; counters are 0 after release.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state encoding and parameter checks for the reset sequencer
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_FILTER  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_t;

  function automatic bit seq_params_legal(int num_stages, int lock_filter,
                                          int stage_delay, int sync_cycle);
    return (num_stages >= 1) && (num_stages <= 8) && (lock_filter >= 1) &&
           (stage_delay >= 1) && (sync_cycle >= 2);
  endfunction

  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - lock/request inputs and sequenced reset outputs of the sequencer
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES = 4
);
  logic                  i_pll_locked;
  logic                  i_sw_rst_req;
  logic [NUM_STAGES-1:0] o_srst;
  logic                  o_rst_done;
  seq_state_t            o_state;

  modport master (
    output i_pll_locked, i_sw_rst_req,
    input  o_srst, o_rst_done, o_state
  );

  modport slave (
    input  i_pll_locked, i_sw_rst_req,
    output o_srst, o_rst_done, o_state
  );
endinterface

// File: rtl/common_reset.sv
// rtl/common_reset.sv - async-assert, sync-release reset synchronizer with selectable polarities
module common_reset #(
  parameter string IN_RST_ACTIVE  = "LOW",
  parameter string OUT_RST_ACTIVE = "HIGH",
  parameter int    CYCLE          = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_rst
);

  // chain holds ones while reset is asserted; zeros walk in after release
  logic [CYCLE-1:0] chain;

  if (IN_RST_ACTIVE == "LOW") begin : g_in_low
    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) chain <= '1;
      else        chain <= {chain[CYCLE-2:0], 1'b0};
    end
  end else begin : g_in_high
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) chain <= '1;
      else       chain <= {chain[CYCLE-2:0], 1'b0};
    end
  end

  assign o_rst = (OUT_RST_ACTIVE == "HIGH") ? chain[CYCLE-1] : ~chain[CYCLE-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - holds reset domains until PLL lock is stable, then releases them in order
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int LOCK_FILTER = 256,
  parameter int STAGE_DELAY = 1024,
  parameter int SYNC_CYCLE  = 2
) (
  input  logic              i_clk,
  input  logic              i_arst,
  reset_sequencer_if.slave  bus
);

  localparam int FW = cnt_width(LOCK_FILTER);
  localparam int DW = cnt_width(STAGE_DELAY);
  localparam int SW = cnt_width(NUM_STAGES);
  localparam logic [FW-1:0] FILTER_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [DW-1:0] DELAY_LAST  = DW'(STAGE_DELAY - 1);
  localparam logic [SW-1:0] STAGE_LAST  = SW'(NUM_STAGES - 1);

  if (!seq_params_legal(NUM_STAGES, LOCK_FILTER, STAGE_DELAY, SYNC_CYCLE)) begin : g_param_check
    $error("reset_sequencer: illegal parameter combination");
  end

  logic rst_int;

  common_reset #(
    .IN_RST_ACTIVE  ("LOW"),
    .OUT_RST_ACTIVE ("HIGH"),
    .CYCLE          (SYNC_CYCLE)
  ) u_arst_sync (
    .i_clk (i_clk),
    .i_rst (i_arst),
    .o_rst (rst_int)
  );

  logic [SYNC_CYCLE-1:0] lock_sync;
  logic                  lock_s;

  always_ff @(posedge i_clk or posedge rst_int) begin
    if (rst_int) lock_sync <= '0;
    else         lock_sync <= {lock_sync[SYNC_CYCLE-2:0], bus.i_pll_locked};
  end

  assign lock_s = lock_sync[SYNC_CYCLE-1];

  seq_state_t            state;
  logic [FW-1:0]         filter_cnt;
  logic [DW-1:0]         delay_cnt;
  logic [SW-1:0]         stage_cnt;
  logic [NUM_STAGES-1:0] srst;
  logic                  rst_done;
  logic                  abort;

  assign abort = !lock_s || bus.i_sw_rst_req;

  always_ff @(posedge i_clk or posedge rst_int) begin
    if (rst_int) begin
      state      <= ST_HOLD;
      filter_cnt <= '0;
      delay_cnt  <= '0;
      stage_cnt  <= '0;
      srst       <= '1;
      rst_done   <= 1'b0;
    end else if (state != ST_HOLD && abort) begin
      // every domain re-asserts together; released bits never re-assert one by one
      state      <= ST_HOLD;
      filter_cnt <= '0;
      delay_cnt  <= '0;
      stage_cnt  <= '0;
      srst       <= '1;
      rst_done   <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (lock_s) begin
            state      <= ST_FILTER;
            filter_cnt <= '0;
          end
        end
        ST_FILTER: begin
          if (filter_cnt == FILTER_LAST) begin
            srst[0]    <= 1'b0;
            filter_cnt <= '0;
            delay_cnt  <= '0;
            stage_cnt  <= SW'(1);
            if (NUM_STAGES == 1) begin
              state    <= ST_RUN;
              rst_done <= 1'b1;
            end else begin
              state    <= ST_RELEASE;
            end
          end else begin
            filter_cnt <= filter_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (delay_cnt == DELAY_LAST) begin
            delay_cnt <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
              if (stage_cnt == SW'(k)) srst[k] <= 1'b0;
            end
            if (stage_cnt == STAGE_LAST) begin
              state    <= ST_RUN;
              rst_done <= 1'b1;
            end else begin
              stage_cnt <= stage_cnt + 1'b1;
            end
          end else begin
            delay_cnt <= delay_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_srst     = srst;
  assign bus.o_rst_done = rst_done;
  assign bus.o_state    = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed bench for reset_sequencer with an expected-event scoreboard
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int NS = 3;

  logic i_clk  = 1'b0;
  logic i_arst = 1'b1;

  always #5 i_clk = ~i_clk;

  reset_sequencer_if #(.NUM_STAGES(NS)) bus ();

  reset_sequencer #(
    .NUM_STAGES  (NS),
    .LOCK_FILTER (8),
    .STAGE_DELAY (4),
    .SYNC_CYCLE  (2)
  ) dut (
    .i_clk  (i_clk),
    .i_arst (i_arst),
    .bus    (bus)
  );

  typedef struct {
    string      tag;
    int         gap;
    logic [2:0] srst;
    logic       done;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_outs(string tag, logic [2:0] srst, logic done, logic [1:0] st);
    chk({tag, "_srst"}, 32'(bus.o_srst), 32'(srst));
    chk({tag, "_done"}, 32'(bus.o_rst_done), 32'(done));
    chk({tag, "_state"}, 32'(bus.o_state), 32'(st));
  endtask

  task automatic push_exp(string tag, int gap, logic [2:0] srst, logic done, logic [1:0] st);
    exp_t e;
    e.tag  = tag;
    e.gap  = gap;
    e.srst = srst;
    e.done = done;
    e.st   = st;
    sb.push_back(e);
  endtask

  // full release sequence, measured from the FILTER-entry edge
  task automatic push_seq(string p);
    push_exp({p, "_s0"}, 8, 3'b110, 1'b0, 2'd2);
    push_exp({p, "_s1"}, 4, 3'b100, 1'b0, 2'd2);
    push_exp({p, "_s2"}, 4, 3'b000, 1'b1, 2'd3);
  endtask

  task automatic wait_state(seq_state_t target, int bound, output int n);
    n = 0;
    while (bus.o_state !== target && n < bound) begin
      step();
      n++;
    end
  endtask

  task automatic wait_srst_change(int bound, output int n);
    logic [2:0] prev;
    prev = bus.o_srst;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.o_srst === prev && n < bound);
  endtask

  task automatic drain();
    exp_t e;
    int   n;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      wait_srst_change(e.gap + 16, n);
      chk({e.tag, "_gap"}, 32'(n), 32'(e.gap));
      chk_outs(e.tag, e.srst, e.done, e.st);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.i_pll_locked = 1'b1;
    bus.i_sw_rst_req = 1'b0;

    // power-up: reset asserts with no clock edge
    #2 i_arst = 1'b0;
    #1 chk_outs("arst_async", 3'b111, 1'b0, 2'd0);
    step(); step(); step();
    chk_outs("arst_hold", 3'b111, 1'b0, 2'd0);
    i_arst = 1'b1;
    wait_state(ST_FILTER, 20, n);
    chk("pwr_filter_gap", 32'(n), 32'd5);
    chk_outs("pwr_filter", 3'b111, 1'b0, 2'd1);
    push_seq("pwr");
    drain();

    // lock loss in RUN: all asserted SYNC_CYCLE+1 edges after the raw drop
    push_exp("loss", 3, 3'b111, 1'b0, 2'd0);
    bus.i_pll_locked = 1'b0;
    drain();
    bus.i_pll_locked = 1'b1;
    wait_state(ST_FILTER, 20, n);
    chk("loss_filter_gap", 32'(n), 32'd3);
    push_seq("loss");
    drain();

    // request in RUN, then lock glitch at filter count 5
    bus.i_sw_rst_req = 1'b1;
    step();
    bus.i_sw_rst_req = 1'b0;
    chk_outs("req_run", 3'b111, 1'b0, 2'd0);
    step();
    chk_outs("rerun_filter", 3'b111, 1'b0, 2'd1);
    step(); step(); step();
    bus.i_pll_locked = 1'b0;
    step();
    bus.i_pll_locked = 1'b1;
    step();
    chk_outs("glitch_still_filter", 3'b111, 1'b0, 2'd1);
    step();
    chk_outs("glitch_hold", 3'b111, 1'b0, 2'd0);
    step();
    chk_outs("glitch_refilter", 3'b111, 1'b0, 2'd1);
    push_seq("glitch");
    drain();

    // request during the one HOLD cycle of a re-run is ignored
    bus.i_sw_rst_req = 1'b1;
    step();
    chk_outs("req2_run", 3'b111, 1'b0, 2'd0);
    step();
    bus.i_sw_rst_req = 1'b0;
    chk_outs("req_in_hold_ignored", 3'b111, 1'b0, 2'd1);
    push_exp("mid_s0", 8, 3'b110, 1'b0, 2'd2);
    drain();

    // request mid-RELEASE
    step();
    bus.i_sw_rst_req = 1'b1;
    step();
    bus.i_sw_rst_req = 1'b0;
    chk_outs("req_release", 3'b111, 1'b0, 2'd0);
    step();
    chk_outs("req_release_refilter", 3'b111, 1'b0, 2'd1);
    push_seq("midreq");
    drain();

    // lock loss and request sampled on the same edge in RUN
    bus.i_pll_locked = 1'b0;
    step(); step();
    chk_outs("simul_pre", 3'b000, 1'b1, 2'd3);
    bus.i_sw_rst_req = 1'b1;
    step();
    bus.i_sw_rst_req = 1'b0;
    chk_outs("simul", 3'b111, 1'b0, 2'd0);
    step(); step();
    chk_outs("simul_stay_hold", 3'b111, 1'b0, 2'd0);
    bus.i_pll_locked = 1'b1;
    wait_state(ST_FILTER, 20, n);
    chk("simul_filter_gap", 32'(n), 32'd3);
    push_seq("simul");
    drain();

    // async reset mid-RELEASE, then a clean sequence proves counters restarted
    bus.i_sw_rst_req = 1'b1;
    step();
    bus.i_sw_rst_req = 1'b0;
    step();
    push_exp("arst_mid_s0", 8, 3'b110, 1'b0, 2'd2);
    drain();
    step(); step();
    #3 i_arst = 1'b0;
    #1 chk_outs("arst_mid_async", 3'b111, 1'b0, 2'd0);
    step(); step();
    i_arst = 1'b1;
    wait_state(ST_FILTER, 20, n);
    chk("arst_mid_filter_gap", 32'(n), 32'd5);
    push_seq("arst_mid");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
